serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  first operand; sampled only on the edge that accepts start.
REQ-006 b  input  WIDTH  second operand; sampled only on the edge that accepts start.
REQ-007 cin  input  1  carry-in; sampled only on the edge that accepts start.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse marking a new valid result.
REQ-010 sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the last completed addition.

Function
REQ-012 The block SHALL add the two operands bit-serially through one internal 1-bit full-add cell: s = x^y^c, c' = (x&y)|(c&(x^y)).
REQ-013 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 busy SHALL be 1 exactly when the state is RUN.
REQ-015 done SHALL be 1 exactly when the state is DONE.
REQ-016 start SHALL be accepted only on an edge where the state is IDLE or DONE (busy=0).
REQ-017 On an accepting edge, the block SHALL:
- latch a, b and cin into internal operand registers;
- load the carry register with cin;
- clear the bit counter;
- enter RUN.
REQ-018 Each edge in RUN SHALL process bit index cnt, LSB first, as follows:
- the partial result bit cnt SHALL take s;
- the carry register SHALL take c';
- cnt SHALL increment.
REQ-019 After the WIDTH-th RUN edge the FSM SHALL enter DONE, and on that same edge:
- sum SHALL load the complete partial result;
- cout SHALL load the final carry.
REQ-020 Latency: if start is accepted on edge k, done SHALL be high during the cycle following edge k+WIDTH.
REQ-021 From DONE, the FSM SHALL enter RUN if start=1; otherwise it SHALL enter IDLE.
REQ-022 Back-to-back operations SHALL therefore complete every WIDTH+1 cycles.
REQ-023 start asserted in RUN SHALL be ignored: it is not queued and has no effect on the operation in progress.
REQ-024 Changes on a, b or cin after the accepting edge SHALL NOT affect the operation in progress.
REQ-025 sum and cout SHALL change only on entry to DONE, and SHALL hold the last result through IDLE and through a subsequent RUN.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during RUN.
REQ-027 With WIDTH=1, RUN SHALL last exactly one cycle.

Reset
REQ-028 When rst_n=0, the block SHALL immediately, without waiting for a clk edge:
- force the state to IDLE;
- clear busy, done, sum and cout to 0;
- clear the operand, carry and counter registers to 0.
REQ-029 Reset asserted mid-RUN SHALL abort the operation, and no done pulse SHALL follow.
REQ-030 After release of rst_n, the first accepting edge SHALL be the first rising edge of clk with start=1.

Verification (WIDTH=8)
REQ-031 Reset during RUN: assert rst_n=0 at cycle 3 of RUN -> busy, done, sum and cout read 0 at once; after release, no done pulse occurs.
REQ-032 Zero sum: a=8'h00, b=8'h00, cin=0, start pulsed at edge k -> done high after edge k+8 for one cycle, sum=8'h00, cout=0, busy high for 8 cycles.
REQ-033 Full carry ripple: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
REQ-034 Carry-in path: a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
REQ-035 Ignored start and operand change: start with a=8'h12, b=8'h34, cin=0; during RUN pulse start with a=8'hFF, b=8'hFF -> exactly one done pulse, sum=8'h46, cout=0.
REQ-036 Back-to-back: start held at 1 with a=8'h80, b=8'h80, cin=0 -> done pulses every 9 cycles, each with sum=8'h00 and cout=1; sum and cout remain stable between pulses.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder with a single full-add cell, sequenced by an IDLE/RUN/DONE FSM
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] ra, rb, part, part_nx;
  logic [CW-1:0] cnt;
  logic c, s, c_nx, last, accept;
  // operands shift right so the cell always sees bit 0; results shift in from the MSB
  assign s       = ra[0] ^ rb[0] ^ c;
  assign c_nx    = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));
  assign part_nx = WIDTH'({s, part} >> 1);
  assign last    = cnt == CW'(WIDTH - 1);
  assign accept  = start && state != RUN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra   <= '0;
      rb   <= '0;
      part <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      ra  <= a;
      rb  <= b;
      c   <= cin;
      cnt <= '0;
    end else if (state == RUN) begin
      ra   <= ra >> 1;
      rb   <= rb >> 1;
      c    <= c_nx;
      cnt  <= cnt + CW'(1);
      part <= part_nx;
      if (last) begin
        sum  <= part_nx;
        cout <= c_nx;
      end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl with WIDTH=8
module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;
  int asserts = 0;
  int fails = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    asserts++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      fails++;
      $display("FAIL reset_async busy=%b done=%b sum=%h cout=%b expected all 0", busy, done, sum, cout);
    end
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    asserts++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic [7:0] es, input logic ec);
    logic [7:0] prev_sum;
    logic prev_cout;
    int busy_cnt;
    prev_sum = sum;
    prev_cout = cout;
    busy_cnt = 0;
    start = 1'b1; a = ta; b = tb; cin = tc;
    tick();
    start = 1'b0; a = ~ta; b = ~tb; cin = ~tc;
    for (int i = 1; i <= 8; i++) begin
      if (busy === 1'b1) busy_cnt++;
      asserts++;
      if (done !== 1'b0 || sum !== prev_sum || cout !== prev_cout) begin
        fails++;
        $display("FAIL %s_run%0d done=%b sum=%h cout=%b expected 0 %h %b", name, i, done, sum, cout, prev_sum, prev_cout);
      end
      tick();
    end
    asserts++;
    if (busy_cnt != 8) begin
      fails++;
      $display("FAIL %s_busy_cycles got %0d expected 8", name, busy_cnt);
    end
    asserts++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== es || cout !== ec) begin
      fails++;
      $display("FAIL %s_result done=%b busy=%b sum=%h cout=%b expected 1 0 %h %b", name, done, busy, sum, cout, es, ec);
    end
    tick();
    asserts++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== es || cout !== ec) begin
      fails++;
      $display("FAIL %s_after done=%b busy=%b sum=%h cout=%b expected 0 0 %h %b", name, done, busy, sum, cout, es, ec);
    end
  endtask

  task automatic test_ignored_start();
    int dones;
    dones = 0;
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) begin
        dones++;
        asserts++;
        if (sum !== 8'h46 || cout !== 1'b0) begin
          fails++;
          $display("FAIL ignored_start_result sum=%h cout=%b expected 46 0", sum, cout);
        end
      end
      tick();
    end
    asserts++;
    if (dones != 1) begin
      fails++;
      $display("FAIL ignored_start_pulses got %0d expected 1", dones);
    end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    dones = 0;
    start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    asserts++;
    if (busy !== 1'b1 || sum !== 8'h46) begin
      fails++;
      $display("FAIL midrun_pre busy=%b sum=%h expected 1 46", busy, sum);
    end
    #2 rst_n = 1'b0;
    #1;
    asserts++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      fails++;
      $display("FAIL midrun_reset busy=%b done=%b sum=%h cout=%b expected all 0", busy, done, sum, cout);
    end
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    asserts++;
    if (dones != 0) begin
      fails++;
      $display("FAIL midrun_no_done got %0d active cycles expected 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
    tick();
    for (int i = 1; i <= 27; i++) begin
      logic exp_done;
      exp_done = (i == 9) || (i == 18) || (i == 27);
      asserts++;
      if (done !== exp_done) begin
        fails++;
        $display("FAIL b2b_done_cycle%0d got %b expected %b", i, done, exp_done);
      end
      if (i >= 9) begin
        asserts++;
        if (sum !== 8'h00 || cout !== 1'b1) begin
          fails++;
          $display("FAIL b2b_result_cycle%0d sum=%h cout=%b expected 00 1", i, sum, cout);
        end
      end
      if (i == 27) start = 1'b0;
      tick();
    end
    asserts++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    run_op("zero_sum", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("carry_in", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    run_op("plain", 8'h3C, 8'h21, 1'b1, 8'h5E, 1'b0);
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
